// File: rtl/mem_arb_pkg.sv
// Shared definitions for the matrix-engine memory arbiter: parameter defaults,
// FSM state encoding and fixed requester indices.
package mem_arb_pkg;

  localparam int NREQ_DEF      = 3;
  localparam int AW_DEF        = 8;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 16;

  localparam int REQ_LOADER  = 0;
  localparam int REQ_COMPUTE = 1;
  localparam int REQ_READOUT = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first requester after last_owner,
// wrapping, so the previous owner is considered last.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int w_best;
    int w_dist;
    w_best = NREQ;
    w_dist = 0;
    pick   = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Distance from last_owner+1 in rotation order; the old owner lands at NREQ-1.
      w_dist = (i + 2 * NREQ - 1 - int'(last_owner)) % NREQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        pick    = '0;
        pick[i] = 1'b1;
        idx     = IW'(i);
      end
    end
    any = (w_best < NREQ);
  end

endmodule

// File: rtl/mat_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port among NREQ
// requesters, with lockable bursts capped at MAX_BURST accesses per grant.
module mat_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               mem_en,
  output logic               mem_wen,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_owner;
  logic [BW-1:0]   r_burst;
  logic [NREQ-1:0] r_rvalid;

  logic [NREQ-1:0] w_pick;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_keep;
  logic            w_en;
  logic            w_wen;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (r_owner),
    .pick       (w_pick),
    .idx        (w_idx),
    .any        (w_any)
  );

  // r_owner doubles as last_owner: it holds the most recent grant even in IDLE.
  assign w_keep = (r_state == ST_OWNED) && req[r_owner] && lock[r_owner] &&
                  ((NREQ == 1) || (r_burst < BURST_LAST));

  always_comb begin
    w_en    = 1'b0;
    w_wen   = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i] && req[i]) begin
        w_en    = 1'b1;
        w_wen   = we[i];
        w_addr  = addr[i*AW +: AW];
        w_wdata = wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_owner  <= IW'(NREQ - 1);
      r_burst  <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= (w_en && !w_wen) ? r_gnt : '0;
      if (w_keep) begin
        r_burst <= r_burst + BW'(1);
      end else if (w_any) begin
        // A lone requester at its burst limit is re-picked here with a fresh count.
        r_state <= ST_OWNED;
        r_gnt   <= w_pick;
        r_owner <= w_idx;
        r_burst <= '0;
      end else begin
        r_state <= ST_IDLE;
        r_gnt   <= '0;
        r_burst <= '0;
      end
    end
  end

  assign gnt       = r_gnt;
  assign busy      = |r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = mem_rdata;
  assign mem_en    = w_en;
  assign mem_wen   = w_wen;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// Bench for mat_mem_arbiter: fixed vector table, burst/reset sequences, and
// randomized traffic checked against a cycle-level behavioural model.
module tb_mat_mem_arbiter;

  localparam int N    = 3;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req, lock, we;
  logic [23:0] addr, wdata;
  logic [2:0]  gnt, rvalid;
  logic        mem_en, mem_wen, busy;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata, rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mat_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy)
  );

  // Synchronous-read memory behind the shared port.
  logic       mem_ready;
  logic [7:0] mem_arr [256];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 256; a++) mem_arr[a] <= 8'(a) ^ 8'h5A;
    end else if (mem_en) begin
      if (mem_wen) mem_arr[mem_addr] <= mem_wdata;
      mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = nobody), rotation pointer, length of current tenure.
  int         m_owner, m_last, m_run;
  logic [2:0] m_rv;
  logic [7:0] m_rdexp;
  logic [7:0] ref_mem [256];

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_run   = 0;
    m_rv    = '0;
    m_rdexp = '0;
  endtask

  task automatic model_check();
    logic [2:0] eg;
    logic       acc;
    eg  = '0;
    acc = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      acc = req[m_owner];
    end
    check("rnd_gnt", gnt, eg);
    check("rnd_busy", busy, m_owner >= 0);
    check("rnd_en", mem_en, acc);
    if (acc) begin
      check("rnd_wen", mem_wen, we[m_owner]);
      check("rnd_addr", mem_addr, addr[m_owner*8 +: 8]);
      check("rnd_wdata", mem_wdata, wdata[m_owner*8 +: 8]);
    end else begin
      check("rnd_addr_idle", mem_addr, 8'h00);
    end
    check("rnd_rvalid", rvalid, m_rv);
    if (m_rv != 3'b000) check("rnd_rdata", rdata, m_rdexp);
  endtask

  task automatic model_step();
    logic [7:0] a;
    int         found;
    m_rv = '0;
    if (m_owner >= 0 && req[m_owner]) begin
      a = addr[m_owner*8 +: 8];
      if (we[m_owner]) begin
        ref_mem[a] = wdata[m_owner*8 +: 8];
      end else begin
        m_rdexp       = ref_mem[a];
        m_rv[m_owner] = 1'b1;
      end
    end
    if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_run < MAXB) begin
      m_run++;
    end else begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        if (found < 0 && req[(m_last + k) % N]) found = (m_last + k) % N;
      end
      if (found >= 0) begin
        m_owner = found;
        m_last  = found;
        m_run   = 1;
      end else begin
        m_owner = -1;
        m_run   = 0;
      end
    end
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] we;
    logic [2:0] gnt;
    logic       en;
    logic       wen;
    logic [7:0] maddr;
    logic [2:0] rv;
    logic [7:0] rd;
  } vec_t;

  vec_t tv [16];
  int   n1, n2;

  initial begin
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0; mem_ready = 1'b0;
    model_reset();

    #1 rst = 1'b0;
    #1;
    check("rst_gnt", gnt, 3'b000);
    check("rst_rvalid", rvalid, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_en", mem_en, 1'b0);
    @(posedge clk); #1 mem_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Rotation 0,1,2,0; write by 0 then read by 1; lone read by 2; read-back of the write.
    tv[0]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00};
    tv[1]  = '{3'b111, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 8'h3F, 3'b000, 8'h00};
    tv[2]  = '{3'b111, 3'b000, 3'b000, 3'b010, 1'b1, 1'b0, 8'h22, 3'b001, 8'h65};
    tv[3]  = '{3'b111, 3'b000, 3'b000, 3'b100, 1'b1, 1'b0, 8'h05, 3'b010, 8'h78};
    tv[4]  = '{3'b011, 3'b000, 3'b001, 3'b001, 1'b1, 1'b1, 8'h3F, 3'b100, 8'h5F};
    tv[5]  = '{3'b010, 3'b000, 3'b000, 3'b010, 1'b1, 1'b0, 8'h22, 3'b000, 8'h00};
    tv[6]  = '{3'b000, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 8'h00, 3'b010, 8'h78};
    tv[7]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00};
    tv[8]  = '{3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00};
    tv[9]  = '{3'b100, 3'b000, 3'b000, 3'b100, 1'b1, 1'b0, 8'h05, 3'b000, 8'h00};
    tv[10] = '{3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 8'h00, 3'b100, 8'h5F};
    tv[11] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00};
    tv[12] = '{3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00};
    tv[13] = '{3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 8'h3F, 3'b000, 8'h00};
    tv[14] = '{3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 8'h00, 3'b001, 8'hA5};
    tv[15] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00};

    addr  = {8'h05, 8'h22, 8'h3F};
    wdata = {8'h00, 8'h00, 8'hA5};
    for (int k = 0; k < 16; k++) begin
      req = tv[k].req; lock = tv[k].lock; we = tv[k].we;
      @(negedge clk);
      check($sformatf("tv%0d_gnt", k), gnt, tv[k].gnt);
      check($sformatf("tv%0d_busy", k), busy, tv[k].gnt != 3'b000);
      check($sformatf("tv%0d_en", k), mem_en, tv[k].en);
      check($sformatf("tv%0d_wen", k), mem_wen, tv[k].wen);
      check($sformatf("tv%0d_addr", k), mem_addr, tv[k].maddr);
      check($sformatf("tv%0d_rvalid", k), rvalid, tv[k].rv);
      if (tv[k].rv != 3'b000) check($sformatf("tv%0d_rdata", k), rdata, tv[k].rd);
      @(posedge clk); #1;
    end

    // Locked burst by requester 1 with requester 0 waiting.
    req = 3'b010; lock = 3'b010; we = 3'b000;
    @(posedge clk); #1;
    check("burst_start", gnt, 3'b010);
    req = 3'b011;
    n1 = 0;
    while (gnt == 3'b010 && n1 < 40) begin
      n1++;
      @(posedge clk); #1;
    end
    check("burst_len", n1, 16);
    check("burst_rot_gnt", gnt, 3'b001);
    check("burst_rot_en", mem_en, 1'b1);
    @(posedge clk); #1;
    check("burst_back", gnt, 3'b010);
    req = 3'b010;

    // Lone locked requester keeps the port across the burst limit.
    n2 = 0;
    repeat (40) begin
      if (gnt == 3'b010 && mem_en) n2++;
      @(posedge clk); #1;
    end
    check("solo_hold", n2, 40);

    // Asynchronous reset in the middle of the burst.
    #3 rst = 1'b0;
    #1;
    check("arst_gnt", gnt, 3'b000);
    check("arst_en", mem_en, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_rvalid", rvalid, 3'b000);
    req = 3'b011; lock = 3'b000;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("arst_first_gnt", gnt, 3'b001);
    check("arst_first_en", mem_en, 1'b1);

    // Randomized traffic against the model.
    rst = 1'b0; req = '0; lock = '0; we = '0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int a = 0; a < 256; a++) ref_mem[a] = mem_arr[a];
    @(posedge clk); #1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        lock[i] = ($urandom_range(0, 3) != 0);
      end
      we    = 3'($urandom_range(0, 7));
      addr  = 24'($urandom());
      wdata = 24'($urandom());
      @(negedge clk);
      model_check();
      model_step();
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
